// File: rtl/dii_package.sv
// ============================================================================
// Module : dii_package
// Brief  : Shared DII flit type and flit assembly helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    function automatic dii_flit dii_flit_assemble(
        input logic        m_valid,
        input logic        m_last,
        input logic [15:0] m_data
    );
        dii_flit f;
        f.valid = m_valid;
        f.last  = m_last;
        f.data  = m_data;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dii_rr_select.sv
// ============================================================================
// Module : dii_rr_select
// Brief  : Combinational round-robin picker; scans from (last+1) mod PORTS.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dii_rr_select #(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] last,
    output logic [$clog2(PORTS)-1:0] index,
    output logic                     any
);

    localparam int c_IDX_W = $clog2(PORTS);

    always_comb begin
        int j;
        j     = 0;
        index = '0;
        any   = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            j = (int'(last) + k) % PORTS;
            if (!any && req[j]) begin
                any   = 1'b1;
                index = c_IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dii_packet_arbiter.sv
// ============================================================================
// Module : dii_packet_arbiter
// Brief  : Zero-latency round-robin packet arbiter merging PORTS DII streams.
//          Optional per-port packet counters under macro DII_ARB_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dii_packet_arbiter
    import dii_package::*;
#(
    parameter int PORTS = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  dii_flit [PORTS-1:0]        flit_in,
    output logic    [PORTS-1:0]        flit_in_ready,
    output dii_flit                    flit_out,
    input  logic                       flit_out_ready,
    output logic [$clog2(PORTS)-1:0]   grant,
    output logic                       locked
`ifdef DII_ARB_STATS_EN
    ,
    output logic [PORTS-1:0][CNT_W-1:0] pkt_count
`endif
);

    localparam int                 c_IDX_W    = $clog2(PORTS);
    localparam logic [0:0]         c_IDLE     = 1'b0;
    localparam logic [0:0]         c_LOCKED   = 1'b1;
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(PORTS - 1);

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_last_grant;
    logic [PORTS-1:0]   w_req;
    logic [c_IDX_W-1:0] w_pick;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_any;
    logic               w_xfer;
    dii_flit            w_flit;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_req[i] = flit_in[i].valid;
        end
    end

    dii_rr_select #(
        .PORTS (PORTS)
    ) u_rr_select (
        .req   (w_req),
        .last  (r_last_grant),
        .index (w_pick),
        .any   (w_any)
    );

    // r_last_grant doubles as the frozen selection while LOCKED
    always_comb begin
        if (r_state == c_LOCKED || !w_any) begin
            w_sel = r_last_grant;
        end else begin
            w_sel = w_pick;
        end
        w_flit         = flit_in[w_sel];
        flit_out       = w_flit;
        flit_out.valid = w_flit.valid & rst_n;
        flit_in_ready  = '0;
        if (rst_n && flit_out_ready) begin
            flit_in_ready[w_sel] = 1'b1;
        end
    end

    assign w_xfer = flit_out.valid & flit_out_ready;
    assign grant  = rst_n ? w_sel : '0;
    assign locked = (r_state == c_LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= c_LAST_RST;
        end else if (w_xfer) begin
            r_last_grant <= w_sel;
            r_state      <= w_flit.last ? c_IDLE : c_LOCKED;
        end
    end

`ifdef DII_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (w_xfer && w_flit.last && w_sel == c_IDX_W'(i)) begin
                    pkt_count[i] <= pkt_count[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dii_packet_arbiter.sv
// ============================================================================
// Module : tb_dii_packet_arbiter
// Brief  : Directed self-checking bench for dii_packet_arbiter (PORTS=2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dii_packet_arbiter;
    import dii_package::*;

    localparam int PORTS = 2;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst_n;
    dii_flit [PORTS-1:0] flit_in;
    logic [PORTS-1:0]   flit_in_ready;
    dii_flit            flit_out;
    logic               flit_out_ready;
    logic [$clog2(PORTS)-1:0] grant;
    logic               locked;
`ifdef DII_ARB_STATS_EN
    logic [PORTS-1:0][CNT_W-1:0] pkt_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dii_packet_arbiter #(
        .PORTS (PORTS),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flit_in        (flit_in),
        .flit_in_ready  (flit_in_ready),
        .flit_out       (flit_out),
        .flit_out_ready (flit_out_ready),
        .grant          (grant),
        .locked         (locked)
`ifdef DII_ARB_STATS_EN
        ,
        .pkt_count      (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic l, input logic [15:0] d);
        flit_in[p] = dii_flit_assemble(v, l, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle, then compare the merged output against the expected flit
    task automatic cyc(input string tag, input logic ev, input logic [15:0] ed,
                       input int eg, input logic el);
        #1;
        check({tag, ".valid"}, 32'(flit_out.valid), 32'(ev));
        if (ev) check({tag, ".data"}, 32'(flit_out.data), 32'(ed));
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".locked"}, 32'(locked), 32'(el));
    endtask

    initial begin
        rst_n          = 1'b0;
        flit_out_ready = 1'b1;
        drive(0, 1'b1, 1'b1, 16'hA000);
        drive(1, 1'b1, 1'b1, 16'hB000);
        #1;
        check("rst.valid", 32'(flit_out.valid), 32'd0);
        check("rst.ready", 32'(flit_in_ready), 32'd0);
        check("rst.locked", 32'(locked), 32'd0);
        check("rst.grant", 32'(grant), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 3-flit packet on port 0 while port 1 waits
        drive(0, 1'b1, 1'b0, 16'hA000);
        drive(1, 1'b1, 1'b1, 16'hB000);
        cyc("p3_f0", 1'b1, 16'hA000, 0, 1'b0);
        check("p3_f0.ready", 32'(flit_in_ready), 32'd1);
        tick();
        drive(0, 1'b1, 1'b0, 16'hA001);
        cyc("p3_f1", 1'b1, 16'hA001, 0, 1'b1);
        tick();
        drive(0, 1'b1, 1'b1, 16'hA002);
        cyc("p3_f2", 1'b1, 16'hA002, 0, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000);
        cyc("idle", 1'b0, 16'h0000, 0, 1'b0);
        tick();
        drive(0, 1'b1, 1'b1, 16'hA003);
        drive(1, 1'b1, 1'b1, 16'hB000);
        cyc("rr_p1", 1'b1, 16'hB000, 1, 1'b0);
        tick();

        // continuous single-flit packets alternate grants
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 1'b1, 16'hA010 + 16'(k));
            drive(1, 1'b1, 1'b1, 16'hB010 + 16'(k));
            cyc($sformatf("alt%0d", k), 1'b1,
                (k % 2 == 0) ? 16'hA010 + 16'(k) : 16'hB010 + 16'(k),
                k % 2, 1'b0);
            tick();
        end

        // port 1 packet with a 2-cycle valid gap; port 0 must not sneak in
        drive(0, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'hB020);
        cyc("gap_f0", 1'b1, 16'hB020, 1, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 1'b1, 16'hA020);
            drive(1, 1'b0, 1'b0, 16'h0000);
            cyc($sformatf("bubble%0d", k), 1'b0, 16'h0000, 1, 1'b1);
            check($sformatf("bubble%0d.ready", k), 32'(flit_in_ready), 32'd2);
            tick();
        end
        drive(1, 1'b1, 1'b1, 16'hB021);
        cyc("gap_f1", 1'b1, 16'hB021, 1, 1'b1);
        tick();
        drive(1, 1'b0, 1'b0, 16'h0000);
        cyc("gap_after", 1'b1, 16'hA020, 0, 1'b0);
        tick();

        // downstream stall in the middle of a packet
        drive(0, 1'b1, 1'b0, 16'hA030);
        cyc("stall_f0", 1'b1, 16'hA030, 0, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 16'hA031);
        flit_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc($sformatf("stall%0d", k), 1'b1, 16'hA031, 0, 1'b1);
            check($sformatf("stall%0d.ready", k), 32'(flit_in_ready), 32'd0);
            tick();
        end
        flit_out_ready = 1'b1;
        cyc("stall_f1", 1'b1, 16'hA031, 0, 1'b1);
        check("stall_f1.ready", 32'(flit_in_ready), 32'd1);
        tick();
        drive(0, 1'b1, 1'b1, 16'hA032);
        cyc("stall_f2", 1'b1, 16'hA032, 0, 1'b1);
        tick();

        // reset in the middle of a port 1 packet
        drive(0, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'hB040);
        cyc("rstmid_f0", 1'b1, 16'hB040, 1, 1'b0);
        tick();
        drive(0, 1'b1, 1'b1, 16'hA040);
        drive(1, 1'b1, 1'b0, 16'hB041);
        cyc("rstmid_f1", 1'b1, 16'hB041, 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid.valid", 32'(flit_out.valid), 32'd0);
        check("rstmid.ready", 32'(flit_in_ready), 32'd0);
        check("rstmid.locked", 32'(locked), 32'd0);
        check("rstmid.grant", 32'(grant), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1, 1'b1, 1'b1, 16'hB042);
        cyc("post_rst0", 1'b1, 16'hA040, 0, 1'b0);
        tick();
        cyc("post_rst1", 1'b1, 16'hB042, 1, 1'b0);
        tick();

`ifdef DII_ARB_STATS_EN
        rst_n = 1'b0;
        #1;
        check("cnt_rst", 32'(pkt_count), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b1, 1'b1, 16'hB050);
        repeat (17) tick();
        check("cnt1_wrap", 32'(pkt_count[1]), 32'd1);
        check("cnt0", 32'(pkt_count[0]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
